// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - APU frame sequencer: quarter/half-frame step pulses, $4017 register, frame IRQ
module frame_sequencer #(
    parameter int CNT_W    = 15,
    parameter int S1       = 3728,
    parameter int S2       = 7456,
    parameter int S3       = 11185,
    parameter int S4       = 14914,
    parameter int S5       = 18640,
    parameter int WR_DELAY = 2
) (
    input  logic       ACLK1,
    input  logic       RES,
    input  logic       W4017,
    input  logic [7:0] DB,
    input  logic       n_R4015,
    output logic       nLFO1,
    output logic       nLFO2,
    output logic       INT_FRAME,
    output logic       MODE5
);

    localparam int DLY_W = $clog2(WR_DELAY + 1);

    localparam logic [CNT_W-1:0] C_S1 = CNT_W'(S1);
    localparam logic [CNT_W-1:0] C_S2 = CNT_W'(S2);
    localparam logic [CNT_W-1:0] C_S3 = CNT_W'(S3);
    localparam logic [CNT_W-1:0] C_S4 = CNT_W'(S4);
    localparam logic [CNT_W-1:0] C_S5 = CNT_W'(S5);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(WR_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             mode5;
    logic             irq_inh;
    logic             irq_flag;
    logic             pend_mode;
    logic [DLY_W-1:0] dly;
    logic             n_lfo1_q;
    logic             n_lfo2_q;

    logic at_last;
    logic quarter;
    logic half;
    logic restart;
    logic irq_set;
    logic unused_db;

    assign unused_db = ^DB[5:0];

    always_comb begin
        at_last = mode5 ? (cnt == C_S5) : (cnt == C_S4);
        half    = (cnt == C_S2) || at_last;
        quarter = (cnt == C_S1) || (cnt == C_S3) || half;
        // A write landing on the final delay cycle reloads the delay instead of restarting.
        restart = (dly == DLY_ONE) && !W4017;
        irq_set = (cnt == C_S4) && !mode5 && !irq_inh && !restart;
    end

    always_ff @(posedge ACLK1 or posedge RES) begin
        if (RES) begin
            cnt   <= '0;
            mode5 <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            mode5 <= pend_mode;
        end else if (at_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The restart edge replaces the old-count decode with the immediate 5-step clock.
    always_ff @(posedge ACLK1 or posedge RES) begin
        if (RES) begin
            n_lfo1_q <= 1'b1;
            n_lfo2_q <= 1'b1;
        end else if (restart) begin
            n_lfo1_q <= !pend_mode;
            n_lfo2_q <= !pend_mode;
        end else begin
            n_lfo1_q <= !quarter;
            n_lfo2_q <= !half;
        end
    end

    always_ff @(posedge ACLK1 or posedge RES) begin
        if (RES) begin
            irq_inh   <= 1'b0;
            pend_mode <= 1'b0;
            dly       <= '0;
        end else if (W4017) begin
            irq_inh   <= DB[6];
            pend_mode <= DB[7];
            dly       <= DLY_LOAD;
        end else if (dly != '0) begin
            dly <= dly - 1'b1;
        end
    end

    always_ff @(posedge ACLK1 or posedge RES) begin
        if (RES) begin
            irq_flag <= 1'b0;
        end else if (W4017 && DB[6]) begin
            irq_flag <= 1'b0;
        end else if (irq_set) begin
            irq_flag <= 1'b1;
        end else if (!n_R4015) begin
            irq_flag <= 1'b0;
        end
    end

    assign nLFO1     = n_lfo1_q;
    assign nLFO2     = n_lfo2_q;
    assign INT_FRAME = irq_flag;
    assign MODE5     = mode5;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer against an event-time frame model
module tb_frame_sequencer;

    localparam int S1 = 3728;
    localparam int S2 = 7456;
    localparam int S3 = 11185;
    localparam int S4 = 14914;
    localparam int S5 = 18640;
    localparam int WR_DELAY = 2;

    logic       ACLK1 = 1'b0;
    logic       RES = 1'b0;
    logic       W4017 = 1'b0;
    logic [7:0] DB = 8'h00;
    logic       n_R4015 = 1'b1;
    logic       nLFO1;
    logic       nLFO2;
    logic       INT_FRAME;
    logic       MODE5;

    frame_sequencer #(
        .CNT_W(15), .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .WR_DELAY(WR_DELAY)
    ) dut (
        .ACLK1(ACLK1),
        .RES(RES),
        .W4017(W4017),
        .DB(DB),
        .n_R4015(n_R4015),
        .nLFO1(nLFO1),
        .nLFO2(nLFO2),
        .INT_FRAME(INT_FRAME),
        .MODE5(MODE5)
    );

    always #5 ACLK1 = ~ACLK1;

    typedef struct {
        int   k;
        logic n1;
        logic n2;
        logic irq;
        logic m5;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Model: the frame is described by the edge at which it started and its mode.
    int edge_n = 0;
    int fstart = 0;
    bit m5 = 0;
    bit inh = 0;
    bit irq = 0;
    bit pend_valid = 0;
    bit pend_mode = 0;
    int pend_edge = 0;

    int lfo1_cnt = 0;
    int lfo2_cnt = 0;
    int first_q_edge = -1;
    int int_rise_edge = -1;
    bit prev_int = 0;

    function automatic int cur_cnt();
        return (edge_n - fstart) % (m5 ? S5 + 1 : S4 + 1);
    endfunction

    function automatic bit is_quarter(input int p);
        return p == S1 || p == S2 || p == S3 || p == (m5 ? S5 : S4);
    endfunction

    function automatic bit is_half(input int p);
        return p == S2 || p == (m5 ? S5 : S4);
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fstart = edge_n;
        m5 = 0;
        inh = 0;
        irq = 0;
        pend_valid = 0;
    endtask

    task automatic step(input bit w, input logic [7:0] db, input bit nr);
        int   k;
        int   pos;
        bit   rst_edge;
        bit   q;
        bit   h;
        bit   set;
        exp_t e;
        #1;
        W4017 = w;
        DB = db;
        n_R4015 = nr;
        k = edge_n + 1;
        pos = cur_cnt();
        rst_edge = pend_valid && pend_edge == k && !w;
        q = rst_edge ? pend_mode : is_quarter(pos);
        h = rst_edge ? pend_mode : is_half(pos);
        set = !rst_edge && pos == S4 && !m5 && !inh;
        if (w && db[6]) irq = 0;
        else if (set) irq = 1;
        else if (!nr) irq = 0;
        if (w) begin
            inh = db[6];
            pend_valid = 1;
            pend_mode = db[7];
            pend_edge = k + WR_DELAY;
        end
        if (rst_edge) begin
            fstart = k;
            m5 = pend_mode;
            pend_valid = 0;
        end
        edge_n = k;
        e.k = k;
        e.n1 = !q;
        e.n2 = !h;
        e.irq = irq;
        e.m5 = m5;
        sbq.push_back(e);
        @(posedge ACLK1);
        @(negedge ACLK1);
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), 1'b1);
    endtask

    task automatic wr(input logic [1:0] top);
        step(1'b1, {top, 6'($urandom)}, 1'b1);
    endtask

    task automatic run_until_cnt(input int c);
        int guard = 0;
        while (cur_cnt() != c && guard < 20000) begin
            idle();
            guard++;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    always @(negedge ACLK1) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            tests++;
            if ({nLFO1, nLFO2, INT_FRAME, MODE5} !== {e.n1, e.n2, e.irq, e.m5}) begin
                fails++;
                $display("FAIL outputs@edge%0d: got nLFO1=%b nLFO2=%b INT=%b MODE5=%b expected %b %b %b %b",
                         e.k, nLFO1, nLFO2, INT_FRAME, MODE5, e.n1, e.n2, e.irq, e.m5);
            end
            if (nLFO1 === 1'b0) begin
                lfo1_cnt++;
                if (first_q_edge < 0) first_q_edge = e.k;
            end
            if (nLFO2 === 1'b0) lfo2_cnt++;
            if (INT_FRAME === 1'b1 && !prev_int) int_rise_edge = e.k;
            prev_int = (INT_FRAME === 1'b1);
        end
    end

    initial begin
        int rel;
        int r;
        int s1;
        int s2;
        #1 RES = 1'b1;
        repeat (3) @(negedge ACLK1);
        check_int("reset_init", int'({nLFO1, nLFO2, INT_FRAME, MODE5}), 4'b1100);
        RES = 1'b0;
        model_reset();
        rel = edge_n;

        // Two free-running 4-step frames, read clear, and set-wins-over-read.
        run_until_cnt(S4);
        idle();
        settle();
        check_int("first_lfo1", first_q_edge - rel, 3729);
        check_int("int_rise_f1", int_rise_edge - rel, 14915);
        check_int("f1_quarters", lfo1_cnt, 4);
        check_int("f1_halves", lfo2_cnt, 2);
        repeat (3) idle();
        step(1'b0, 8'($urandom), 1'b0);
        idle();
        settle();
        check_int("irq_read_clear", int'(INT_FRAME), 0);
        run_until_cnt(S4);
        step(1'b0, 8'($urandom), 1'b0);
        settle();
        check_int("irq_set_wins", int'(INT_FRAME), 1);
        check_int("int_rise_f2", int_rise_edge - rel, 2 * 14915);

        // Inhibit clears and holds the flag; writing 0x00 re-enables it.
        wr(2'b01);
        settle();
        check_int("inh_clear", int'(INT_FRAME), 0);
        run_until_cnt(S4);
        idle();
        settle();
        check_int("inh_hold", int'(INT_FRAME), 0);
        wr(2'b00);
        run_until_cnt(S4);
        idle();
        settle();
        check_int("reenable", int'(INT_FRAME), 1);

        // Asynchronous reset mid-frame with the flag set and a write pending.
        repeat (5) idle();
        wr(2'b10);
        #2 RES = 1'b1;
        #1 check_int("reset_async", int'({nLFO1, nLFO2, INT_FRAME, MODE5}), 4'b1100);
        repeat (2) @(posedge ACLK1);
        @(negedge ACLK1);
        RES = 1'b0;
        model_reset();
        rel = edge_n;
        first_q_edge = -1;

        // Switch to 5-step at cnt=5000 and run one full 5-step frame.
        run_until_cnt(5000);
        settle();
        check_int("first_lfo1_after_reset", first_q_edge - rel, 3729);
        wr(2'b10);
        r = edge_n + WR_DELAY;
        settle();
        s1 = lfo1_cnt;
        s2 = lfo2_cnt;
        while (edge_n < r + S5 + 1) idle();
        settle();
        check_int("m5_quarters", lfo1_cnt - s1, 5);
        check_int("m5_halves", lfo2_cnt - s2, 3);
        check_int("mode5_out", int'(MODE5), 1);
        check_int("m5_no_irq", int'(INT_FRAME), 0);

        // Back-to-back writes; the single restart lands on the S2 decode edge.
        run_until_cnt(S2 - 3);
        wr(2'b00);
        settle();
        s1 = lfo1_cnt;
        s2 = lfo2_cnt;
        wr(2'b10);
        repeat (3) idle();
        settle();
        check_int("b2b_quarters", lfo1_cnt - s1, 1);
        check_int("b2b_halves", lfo2_cnt - s2, 1);
        check_int("b2b_mode5", int'(MODE5), 1);

        // Random writes and reads near frame start.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 7) != 0);
        end
        settle();
        check_int("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
